wd_apply: RTL and testbench

WD_APPLY -- requirements
Module: wd_apply

---
 rtl/wd_apply.sv | 169 ++++++++++++++++
 tb/tb_wd_apply.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wd_apply.sv
// wd_apply: latches a 2A/2B window command, validates it against the panel size
// and publishes it as the active window. Define WD_FS_SYNC_EN to defer the update to frame_start.
module wd_apply #(
  parameter int unsigned H_MAX = 1080,
  parameter int unsigned V_MAX = 1920
) (
  input  logic        clkrx,
  input  logic        rst_n,
  input  logic        wd_rdy,
  input  logic [7:0]  wd_2a_dats_h,
  input  logic [7:0]  wd_2a_dats_l,
  input  logic [7:0]  wd_2a_date_h,
  input  logic [7:0]  wd_2a_date_l,
  input  logic [7:0]  wd_2b_dats_h,
  input  logic [7:0]  wd_2b_dats_l,
  input  logic [7:0]  wd_2b_date_h,
  input  logic [7:0]  wd_2b_date_l,
  input  logic        frame_start,
  output logic        busy,
  output logic [15:0] win_x0,
  output logic [15:0] win_x1,
  output logic [15:0] win_y0,
  output logic [15:0] win_y1,
  output logic [15:0] win_w,
  output logic [15:0] win_h,
  output logic        win_upd,
  output logic        win_err
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] X_LIM = CW'(H_MAX);
  localparam logic [CW-1:0] Y_LIM = CW'(V_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    CHECK   = 3'd2,
`ifdef WD_FS_SYNC_EN
    WAIT_FS = 3'd3,
`endif
    APPLY   = 3'd4,
    RELEASE = 3'd5
  } state_e;

  state_e          state_q;
  logic            armed_q;
  logic            busy_q;
  logic            win_upd_q;
  logic            win_err_q;
  logic [CW-1:0]   x0_q, x1_q, y0_q, y1_q;
  logic [CW-1:0]   win_x0_q, win_x1_q, win_y0_q, win_y1_q;
  logic [CW-1:0]   win_w_q, win_h_q;

  logic            valid_c;
  logic            apply_c;
  logic [CW-1:0]   w_c;
  logic [CW-1:0]   h_c;

  // Window legality and size, evaluated on the captured shadow copy
  always_comb begin
    valid_c = (x0_q <= x1_q) && (x1_q < X_LIM) && (y0_q <= y1_q) && (y1_q < Y_LIM);
    w_c     = x1_q - x0_q + CW'(1);
    h_c     = y1_q - y0_q + CW'(1);
  end

  // Cycle in which the shadow window is committed to the outputs
`ifdef WD_FS_SYNC_EN
  assign apply_c = (state_q == WAIT_FS) && frame_start;
`else
  assign apply_c = (state_q == CHECK) && valid_c;
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

  always_ff @(posedge clkrx) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      win_upd_q <= 1'b0;
      win_err_q <= 1'b0;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      win_x0_q  <= '0;
      win_x1_q  <= CW'(H_MAX - 1);
      win_y0_q  <= '0;
      win_y1_q  <= CW'(V_MAX - 1);
      win_w_q   <= CW'(H_MAX);
      win_h_q   <= CW'(V_MAX);
    end else begin
      win_upd_q <= 1'b0;

      if (apply_c) begin
        win_x0_q  <= x0_q;
        win_x1_q  <= x1_q;
        win_y0_q  <= y0_q;
        win_y1_q  <= y1_q;
        win_w_q   <= w_c;
        win_h_q   <= h_c;
        win_upd_q <= 1'b1;
        win_err_q <= 1'b0;
      end

      case (state_q)
        // armed only re-arms after wd_rdy is seen low, so a stale level cannot retrigger
        IDLE: begin
          if (!wd_rdy) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= CAPTURE;
            busy_q  <= 1'b1;
          end
        end
        CAPTURE: begin
          x0_q    <= {wd_2a_dats_h, wd_2a_dats_l};
          x1_q    <= {wd_2a_date_h, wd_2a_date_l};
          y0_q    <= {wd_2b_dats_h, wd_2b_dats_l};
          y1_q    <= {wd_2b_date_h, wd_2b_date_l};
          state_q <= CHECK;
        end
        CHECK: begin
          if (!valid_c) begin
            win_err_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= RELEASE;
          end else begin
`ifdef WD_FS_SYNC_EN
            state_q <= WAIT_FS;
`else
            state_q <= APPLY;
`endif
          end
        end
`ifdef WD_FS_SYNC_EN
        WAIT_FS: begin
          if (frame_start) begin
            state_q <= APPLY;
          end
        end
`endif
        APPLY: begin
          busy_q  <= 1'b0;
          state_q <= RELEASE;
        end
        RELEASE: begin
          armed_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign win_upd = win_upd_q;
  assign win_err = win_err_q;
  assign win_x0  = win_x0_q;
  assign win_x1  = win_x1_q;
  assign win_y0  = win_y0_q;
  assign win_y1  = win_y1_q;
  assign win_w   = win_w_q;
  assign win_h   = win_h_q;

endmodule

// File: tb/tb_wd_apply.sv
// tb_wd_apply: self-checking bench for wd_apply; directed scenarios plus random
// window commands checked against a behavioural window model.
module tb_wd_apply;

  localparam int H_MAX = 1080;
  localparam int V_MAX = 1920;
`ifdef WD_FS_SYNC_EN
  localparam int RST_AT = 20;
`else
  localparam int RST_AT = 2;
`endif

  logic        clkrx = 1'b0;
  logic        rst_n;
  logic        wd_rdy;
  logic [7:0]  wd_2a_dats_h, wd_2a_dats_l, wd_2a_date_h, wd_2a_date_l;
  logic [7:0]  wd_2b_dats_h, wd_2b_dats_l, wd_2b_date_h, wd_2b_date_l;
  logic        frame_start;
  logic        busy;
  logic [15:0] win_x0, win_x1, win_y0, win_y1, win_w, win_h;
  logic        win_upd;
  logic        win_err;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;

  logic [15:0] exp_x0, exp_x1, exp_y0, exp_y1, exp_w, exp_h;
  logic        exp_err;

  wd_apply #(.H_MAX(H_MAX), .V_MAX(V_MAX)) dut (
    .clkrx        (clkrx),
    .rst_n        (rst_n),
    .wd_rdy       (wd_rdy),
    .wd_2a_dats_h (wd_2a_dats_h),
    .wd_2a_dats_l (wd_2a_dats_l),
    .wd_2a_date_h (wd_2a_date_h),
    .wd_2a_date_l (wd_2a_date_l),
    .wd_2b_dats_h (wd_2b_dats_h),
    .wd_2b_dats_l (wd_2b_dats_l),
    .wd_2b_date_h (wd_2b_date_h),
    .wd_2b_date_l (wd_2b_date_l),
    .frame_start  (frame_start),
    .busy         (busy),
    .win_x0       (win_x0),
    .win_x1       (win_x1),
    .win_y0       (win_y0),
    .win_y1       (win_y1),
    .win_w        (win_w),
    .win_h        (win_h),
    .win_upd      (win_upd),
    .win_err      (win_err)
  );

  always #5 clkrx = ~clkrx;

  always @(negedge clkrx) if (win_upd === 1'b1) upd_cnt++;

  task automatic set_cmd(input logic [15:0] x0, input logic [15:0] x1,
                         input logic [15:0] y0, input logic [15:0] y1);
    {wd_2a_dats_h, wd_2a_dats_l} = x0;
    {wd_2a_date_h, wd_2a_date_l} = x1;
    {wd_2b_dats_h, wd_2b_dats_l} = y0;
    {wd_2b_date_h, wd_2b_date_l} = y1;
  endtask

  task automatic model_reset();
    exp_x0 = 16'd0;
    exp_x1 = 16'(H_MAX - 1);
    exp_y0 = 16'd0;
    exp_y1 = 16'(V_MAX - 1);
    exp_w  = 16'(H_MAX);
    exp_h  = 16'(V_MAX);
    exp_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wd_rdy = 1'b0; frame_start = 1'b0;
    set_cmd(16'h0, 16'h0, 16'h0, 16'h0);
    model_reset();
    repeat (3) @(negedge clkrx);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (win_upd !== 1'b0) begin failures++; $display("FAIL reset_upd: got %b want 0", win_upd); end
    checks++; if (win_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", win_err); end
    checks++; if ({win_x0, win_x1, win_y0, win_y1} !== {exp_x0, exp_x1, exp_y0, exp_y1}) begin
      failures++; $display("FAIL reset_bounds: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                           win_x0, win_x1, win_y0, win_y1, exp_x0, exp_x1, exp_y0, exp_y1);
    end
    checks++; if ({win_w, win_h} !== {exp_w, exp_h}) begin
      failures++; $display("FAIL reset_size: got %0d x %0d want %0d x %0d", win_w, win_h, exp_w, exp_h);
    end
    rst_n = 1'b1;
    @(negedge clkrx);
  endtask

  // Issue one command and compare outputs against the model once busy has fallen
  task automatic run_cmd(input logic [15:0] x0, input logic [15:0] x1,
                         input logic [15:0] y0, input logic [15:0] y1,
                         input int hold, input bit scramble, input string tag);
    int  base, fs_at;
    bit  seen, done, valid;
    @(negedge clkrx); wd_rdy = 1'b0; frame_start = 1'b0;
    @(negedge clkrx);
    set_cmd(x0, x1, y0, y1);
    wd_rdy = 1'b1;
    base = upd_cnt;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clkrx);
      if (busy === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL %s busy_rise: got %b want 1", tag, busy); end
    if (scramble) begin
      @(negedge clkrx);
      set_cmd(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      wd_rdy = 1'b0;
    end
    fs_at = int'($urandom_range(3, 12));
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clkrx);
      frame_start = (i == fs_at);
      if (busy === 1'b0) done = 1'b1;
    end
    frame_start = 1'b0;
    checks++; if (!done) begin failures++; $display("FAIL %s busy_fall: got %b want 0", tag, busy); end
    repeat (hold) @(negedge clkrx);
    wd_rdy = 1'b0;
    @(negedge clkrx);

    valid = (x0 <= x1) && (int'(x1) < H_MAX) && (y0 <= y1) && (int'(y1) < V_MAX);
    if (valid) begin
      exp_x0 = x0; exp_x1 = x1; exp_y0 = y0; exp_y1 = y1;
      exp_w = x1 - x0 + 16'd1;
      exp_h = y1 - y0 + 16'd1;
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end

    checks++; if (upd_cnt - base !== (valid ? 1 : 0)) begin
      failures++; $display("FAIL %s upd_count: got %0d want %0d", tag, upd_cnt - base, valid ? 1 : 0);
    end
    checks++; if (win_err !== exp_err) begin failures++; $display("FAIL %s err: got %b want %b", tag, win_err, exp_err); end
    checks++; if (win_x0 !== exp_x0) begin failures++; $display("FAIL %s x0: got %0d want %0d", tag, win_x0, exp_x0); end
    checks++; if (win_x1 !== exp_x1) begin failures++; $display("FAIL %s x1: got %0d want %0d", tag, win_x1, exp_x1); end
    checks++; if (win_y0 !== exp_y0) begin failures++; $display("FAIL %s y0: got %0d want %0d", tag, win_y0, exp_y0); end
    checks++; if (win_y1 !== exp_y1) begin failures++; $display("FAIL %s y1: got %0d want %0d", tag, win_y1, exp_y1); end
    checks++; if (win_w !== exp_w) begin failures++; $display("FAIL %s w: got %0d want %0d", tag, win_w, exp_w); end
    checks++; if (win_h !== exp_h) begin failures++; $display("FAIL %s h: got %0d want %0d", tag, win_h, exp_h); end
  endtask

`ifndef WD_FS_SYNC_EN
  task automatic test_latency();
    bit exp_busy, exp_upd;
    @(negedge clkrx); wd_rdy = 1'b0;
    @(negedge clkrx);
    set_cmd(16'h0000, 16'h0437, 16'h0000, 16'h077F);
    wd_rdy = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clkrx);
      exp_busy = (c >= 1 && c <= 3);
      exp_upd  = (c == 3);
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL latency_busy c%0d: got %b want %b", c, busy, exp_busy); end
      checks++; if (win_upd !== exp_upd) begin failures++; $display("FAIL latency_upd c%0d: got %b want %b", c, win_upd, exp_upd); end
      if (c == 3) begin
        checks++; if ({win_w, win_h} !== {16'd1080, 16'd1920}) begin
          failures++; $display("FAIL latency_size: got %0d x %0d want 1080 x 1920", win_w, win_h);
        end
      end
    end
    wd_rdy = 1'b0;
  endtask
`else
  task automatic test_fs_sync();
    int bad;
    @(negedge clkrx); wd_rdy = 1'b0; frame_start = 1'b0;
    @(negedge clkrx);
    set_cmd(16'd10, 16'd109, 16'd20, 16'd219);
    wd_rdy = 1'b1;
    bad = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clkrx);
      if (busy !== 1'b1 || win_upd !== 1'b0) bad++;
      if (c == 50) frame_start = 1'b1;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL fs_wait: got %0d bad cycles want 0", bad); end
    @(negedge clkrx);
    frame_start = 1'b0;
    checks++; if (win_upd !== 1'b1) begin failures++; $display("FAIL fs_upd: got %b want 1", win_upd); end
    checks++; if ({win_x0, win_x1, win_w, win_h} !== {16'd10, 16'd109, 16'd100, 16'd200}) begin
      failures++; $display("FAIL fs_window: got %0d %0d %0d %0d want 10 109 100 200", win_x0, win_x1, win_w, win_h);
    end
    @(negedge clkrx);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fs_busy_fall: got %b want 0", busy); end
    wd_rdy = 1'b0;
    exp_x0 = 16'd10; exp_x1 = 16'd109; exp_y0 = 16'd20; exp_y1 = 16'd219;
    exp_w = 16'd100; exp_h = 16'd200; exp_err = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    int base;
    @(negedge clkrx); wd_rdy = 1'b0;
    @(negedge clkrx);
    set_cmd(16'd5, 16'd50, 16'd6, 16'd60);
    wd_rdy = 1'b1;
    base = upd_cnt;
    repeat (RST_AT) @(negedge clkrx);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    @(negedge clkrx);
    wd_rdy = 1'b0;
    model_reset();
    checks++; if (upd_cnt - base !== 0) begin failures++; $display("FAIL rstmid_upd: got %0d want 0", upd_cnt - base); end
    checks++; if ({win_x0, win_x1, win_y0, win_y1, win_w, win_h} !== {exp_x0, exp_x1, exp_y0, exp_y1, exp_w, exp_h}) begin
      failures++; $display("FAIL rstmid_window: got %0d %0d %0d %0d %0d %0d want full screen",
                           win_x0, win_x1, win_y0, win_y1, win_w, win_h);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy_clr: got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clkrx);
  endtask

  task automatic test_directed();
    run_cmd(16'h0064, 16'h01F3, 16'h00C8, 16'h0257, 0, 1'b0, "valid_400");
    run_cmd(16'h0200, 16'h0100, 16'h0000, 16'h0010, 0, 1'b0, "x_swapped");
    run_cmd(16'h0010, 16'h0020, 16'h0030, 16'h0040, 0, 1'b0, "err_clear");
    run_cmd(16'h0000, 16'h0438, 16'h0000, 16'h077F, 0, 1'b0, "x1_at_hmax");
    run_cmd(16'h0000, 16'h0437, 16'h0000, 16'h0780, 0, 1'b0, "y1_at_vmax");
    run_cmd(16'h0437, 16'h0437, 16'h077F, 16'h077F, 0, 1'b0, "single_px");
  endtask

  task automatic test_back_to_back();
    run_cmd(16'd1, 16'd2, 16'd3, 16'd4, 5, 1'b0, "stale_hold");
    run_cmd(16'd7, 16'd8, 16'd9, 16'd10, 0, 1'b0, "rearm");
    run_cmd(16'd100, 16'd300, 16'd100, 16'd900, 0, 1'b1, "scramble");
  endtask

  task automatic test_random();
    int a0, a1, b0, b1, mode;
    for (int n = 0; n < 24; n++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin
          a0 = int'($urandom_range(0, H_MAX - 1)); a1 = int'($urandom_range(a0, H_MAX - 1));
          b0 = int'($urandom_range(0, V_MAX - 1)); b1 = int'($urandom_range(b0, V_MAX - 1));
        end
        1: begin
          a0 = int'($urandom_range(0, 2047)); a1 = int'($urandom_range(0, 2047));
          b0 = int'($urandom_range(0, 2047)); b1 = int'($urandom_range(0, 2047));
        end
        2: begin
          a0 = int'($urandom_range(0, 20)); a1 = H_MAX - 1 + int'($urandom_range(0, 1));
          b0 = int'($urandom_range(0, 20)); b1 = V_MAX - 1 + int'($urandom_range(0, 1));
        end
        default: begin
          a1 = int'($urandom_range(0, H_MAX - 2)); a0 = a1 + int'($urandom_range(1, 5));
          b0 = int'($urandom_range(0, V_MAX - 1)); b1 = int'($urandom_range(b0, V_MAX - 1));
        end
      endcase
      run_cmd(16'(a0), 16'(a1), 16'(b0), 16'(b1), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
`ifndef WD_FS_SYNC_EN
    test_latency();
`else
    test_fs_sync();
`endif
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    run_cmd(16'h0064, 16'h01F3, 16'h00C8, 16'h0257, 0, 1'b0, "after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
